// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Initiator for a 16-bit ALU port. Takes single-op or sweep
//               commands, drives registered ALU inputs, captures the result
//               after a settle time and returns it on a valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int WIDTH  = 16,
    parameter int OPW    = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sweep,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OPW-1:0]   rsp_op,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             rsp_last,
    output logic             busy
);

    localparam logic [1:0]     c_IDLE      = 2'd0;
    localparam logic [1:0]     c_DRIVE     = 2'd1;
    localparam logic [1:0]     c_RESP      = 2'd2;
    localparam logic [OPW-1:0] c_OP_MAX    = {OPW{1'b1}};
    localparam logic [OPW-1:0] c_OP_ONE    = {{(OPW-1){1'b0}}, 1'b1};
    localparam logic [3:0]     c_SETTLE_LD = 4'(SETTLE - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       r_cnt;
    logic             r_sweep;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_rsp_valid;
    logic [OPW-1:0]   r_rsp_op;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_cout;
    logic             r_rsp_last;

    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_capture;
    logic             w_release;
    logic             w_step;
    logic             w_last_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        w_step       = 1'b0;
        w_last_op    = (r_alu_op == c_OP_MAX);
        case (r_state)
            c_IDLE: begin
                w_cmd_ready = ~rst;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = c_DRIVE;
                end
            end
            c_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_release = 1'b1;
                    // Sweep stops at the all-ones opcode rather than wrapping.
                    if (r_sweep && !w_last_op) begin
                        w_step       = 1'b1;
                        w_next_state = c_DRIVE;
                    end else begin
                        w_next_state = c_IDLE;
                    end
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_sweep     <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= '0;
            r_rsp_y     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= cmd_a;
                r_alu_b  <= cmd_b;
                r_alu_op <= cmd_sweep ? '0 : cmd_op;
                r_sweep  <= cmd_sweep;
                r_cnt    <= c_SETTLE_LD;
            end
            if (r_state == c_DRIVE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_y     <= alu_y;
                r_rsp_cout  <= alu_cout;
                r_rsp_op    <= r_alu_op;
                r_rsp_valid <= 1'b1;
                r_rsp_last  <= ~r_sweep | w_last_op;
            end
            if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_step) begin
                r_alu_op <= r_alu_op + c_OP_ONE;
                r_cnt    <= c_SETTLE_LD;
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_op    = r_rsp_op;
    assign rsp_y     = r_rsp_y;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_last  = r_rsp_last;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Scoreboard bench for alu_cmd_sequencer with an adder ALU stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_sweep = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_op;
    logic [15:0] rsp_y;
    logic        rsp_cout, rsp_last, busy;

    // Second instance built with SETTLE=4
    logic        s4_cmd_valid = 1'b0;
    logic        s4_cmd_ready;
    logic [2:0]  s4_alu_op;
    logic [15:0] s4_alu_a, s4_alu_b, s4_alu_y;
    logic        s4_alu_cout;
    logic        s4_rsp_valid;
    logic        s4_rsp_ready = 1'b0;
    logic [2:0]  s4_rsp_op;
    logic [15:0] s4_rsp_y;
    logic        s4_rsp_cout, s4_rsp_last, s4_busy;
    logic [15:0] s4_mask = 16'd0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] y;
        logic        cout;
        logic        last;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

    logic [16:0] s4_sum;
    assign s4_sum      = {1'b0, s4_alu_a} + {1'b0, s4_alu_b};
    assign s4_alu_cout = s4_sum[16];
    assign s4_alu_y    = s4_sum[15:0] ^ s4_mask;

    alu_cmd_sequencer #(.WIDTH(16), .OPW(3), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sweep(cmd_sweep),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_last(rsp_last), .busy(busy)
    );

    alu_cmd_sequencer #(.WIDTH(16), .OPW(3), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .cmd_valid(s4_cmd_valid), .cmd_ready(s4_cmd_ready), .cmd_sweep(1'b0),
        .cmd_op(3'd5), .cmd_a(16'h1234), .cmd_b(16'h0111),
        .alu_op(s4_alu_op), .alu_a(s4_alu_a), .alu_b(s4_alu_b),
        .alu_y(s4_alu_y), .alu_cout(s4_alu_cout),
        .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready), .rsp_op(s4_rsp_op),
        .rsp_y(s4_rsp_y), .rsp_cout(s4_rsp_cout), .rsp_last(s4_rsp_last), .busy(s4_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every response handshake, checks stability while stalled
    logic        hold_v = 1'b0;
    exp_t        held;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got op %0d y %h expected no response", rsp_op, rsp_y);
            end else begin
                n_tests--;
                e = q.pop_front();
                check("rsp_op",   32'(rsp_op),   32'(e.op));
                check("rsp_y",    32'(rsp_y),    32'(e.y));
                check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                check("rsp_last", 32'(rsp_last), 32'(e.last));
            end
        end
        if (!rst && hold_v) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", {rsp_op, rsp_y, rsp_cout, rsp_last}, 32'(held));
        end
        hold_v = !rst && rsp_valid && !rsp_ready;
        held   = {rsp_op, rsp_y, rsp_cout, rsp_last};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sweep, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_sweep = sweep;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_a     = ~a;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        if (!rsp_valid) check(name, 32'(rsp_valid), 32'd1);
    endtask

    // Hold rsp_ready low for `stall` cycles once a response shows, then accept it
    task automatic serve(input int stall);
        wait_valid("rsp_timeout");
        rsp_ready = 1'b0;
        repeat (stall) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic fin;

        // 1. reset / idle
        rst = 1'b1;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", {alu_op, rsp_valid, rsp_op, rsp_cout, rsp_last, busy}, 32'd0);
        check("rst_alu_a_y", {alu_a, rsp_y}, 32'd0);
        tick();
        check("rst_cmd_ready2", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // 2. single op
        rsp_ready = 1'b1;
        e = '{op: 3'd2, y: 16'h5b90, cout: 1'b0, last: 1'b1};
        q.push_back(e);
        send(1'b0, 3'b010, 16'h5b7f, 16'h0011);
        check("single_alu_op", 32'(alu_op), 32'd2);
        check("single_alu_a", 32'(alu_a), 32'h5b7f);
        check("single_busy", 32'(busy), 32'd1);
        check("single_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("single_valid_on", 32'(rsp_valid), 32'd1);
        tick();
        check("single_valid_off", 32'(rsp_valid), 32'd0);
        check("single_idle", {31'd0, busy}, 32'd0);
        rsp_ready = 1'b0;

        // 3. sweep with back-pressure
        for (int i = 0; i < 8; i++) begin
            e = '{op: 3'(i), y: 16'hcb7e, cout: 1'b0, last: (i == 7)};
            q.push_back(e);
        end
        send(1'b1, 3'd6, 16'h5b7f, 16'h6fff);
        check("sweep_first_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 8; i++) serve(3);
        check("sweep_done", 32'(busy), 32'd0);
        check("sweep_queue", 32'(q.size()), 32'd0);

        // 4. carry and throughput
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = '{op: 3'(i), y: 16'h0000, cout: 1'b1, last: (i == 7)};
            q.push_back(e);
        end
        send(1'b1, 3'd0, 16'hffff, 16'h0001);
        n = 0;
        fin = 1'b0;
        while (!fin && n < 40) begin
            @(negedge clk);
            fin = rsp_valid & rsp_ready & rsp_last;
            @(posedge clk);
            n++;
        end
        #1;
        check("sweep_cycles", 32'(n), 32'd16);
        check("carry_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // 5. reset mid-sweep
        for (int i = 0; i < 3; i++) begin
            e = '{op: 3'(i), y: 16'h0003, cout: 1'b0, last: 1'b0};
            q.push_back(e);
        end
        send(1'b1, 3'd0, 16'h0001, 16'h0002);
        for (int i = 0; i < 3; i++) serve(1);
        wait_valid("mid_rsp_timeout");
        check("mid_rsp_op", 32'(rsp_op), 32'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("mid_after_ready", 32'(cmd_ready), 32'd1);
        check("mid_after_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        rsp_ready = 1'b0;
        check("mid_queue", 32'(q.size()), 32'd0);

        // 6. SETTLE=4 instance: capture reflects stub change on settle cycle 2
        check("s4_ready", 32'(s4_cmd_ready), 32'd1);
        s4_cmd_valid = 1'b1;
        tick();
        s4_cmd_valid = 1'b0;
        check("s4_op", 32'(s4_alu_op), 32'd5);
        check("s4_valid_e0", 32'(s4_rsp_valid), 32'd0);
        tick();
        s4_mask = 16'h00ff;
        check("s4_valid_e1", 32'(s4_rsp_valid), 32'd0);
        tick();
        check("s4_valid_e2", 32'(s4_rsp_valid), 32'd0);
        check("s4_a_stable", {s4_alu_a, s4_alu_b}, 32'h12340111);
        tick();
        check("s4_valid_e3", 32'(s4_rsp_valid), 32'd0);
        check("s4_op_stable", 32'(s4_alu_op), 32'd5);
        tick();
        check("s4_valid_e4", 32'(s4_rsp_valid), 32'd1);
        check("s4_rsp_y", 32'(s4_rsp_y), 32'h13ba);
        check("s4_rsp_misc", {s4_rsp_op, s4_rsp_cout, s4_rsp_last}, 32'b10101);
        s4_rsp_ready = 1'b1;
        tick();
        s4_rsp_ready = 1'b0;
        check("s4_valid_off", 32'(s4_rsp_valid), 32'd0);
        check("s4_idle", 32'(s4_cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
